// File: rtl/ofdm_decode_sequencer.sv
// ofdm_decode_sequencer: per-packet controller for the OFDM decoder chain.
// Runs the decoder over the L-SIG field, checks it, then reconfigures the
// decoder for the DATA field and forwards exactly `length` payload bytes.
// All outputs are registered; next-cycle values come from the output logic
// below and are written together with the state register.
module ofdm_decode_sequencer #(
    parameter int MAX_LEN        = 4095,
    parameter int SKIP_BYTES     = 0,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        start,
    input  logic [7:0]  byte_in,
    input  logic        byte_in_strobe,
    output logic        dec_reset,
    output logic        dec_enable,
    output logic [7:0]  rate,
    output logic        do_descramble,
    output logic [19:0] num_bits_to_decode,
    output logic        sig_valid,
    output logic        sig_error,
    output logic        timeout,
    output logic [3:0]  pkt_rate,
    output logic [11:0] pkt_len,
    output logic [7:0]  data_byte,
    output logic        data_strobe,
    output logic        pkt_done,
    output logic        busy
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SIG_CFG   = 3'd1,
        ST_SIG_WAIT  = 3'd2,
        ST_SIG_CHECK = 3'd3,
        ST_DATA_CFG  = 3'd4,
        ST_DATA      = 3'd5
    } state_t;

    localparam int              TW         = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]   TO_LIMIT   = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0]   TO_ONE     = TW'(1);
    localparam int              SW         = (SKIP_BYTES > 0) ? $clog2(SKIP_BYTES + 1) : 1;
    localparam logic [SW-1:0]   SKIP_LIMIT = SW'(SKIP_BYTES);
    localparam logic [SW-1:0]   SKIP_ONE   = SW'(1);
    localparam logic [12:0]     MAX_LEN_C  = 13'(MAX_LEN);

    // Even parity over the 18 SIG bits that carry rate, reserved, length and parity.
    function automatic logic parity_18(input logic [17:0] bits);
        return ^bits;
    endfunction

    // Legal legacy rate codes; every one of them has bit 3 set.
    function automatic logic rate_known(input logic [3:0] r);
        logic ok;
        case (r)
            4'hB, 4'hF, 4'hA, 4'hE, 4'h9, 4'hD, 4'h8, 4'hC: ok = 1'b1;
            default:                                       ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Full SIG acceptance test on the word {sig2, sig1, sig0}.
    function automatic logic sig_ok(input logic [23:0] w);
        logic [11:0] len;
        len = {w[16], w[15:8], w[7:5]};
        return rate_known(w[3:0]) && (w[4] == 1'b0) && (parity_18(w[17:0]) == 1'b0)
               && (w[23:18] == 6'd0) && (len != 12'd0) && ({1'b0, len} <= MAX_LEN_C);
    endfunction

    state_t        state_r, next_state_s;
    logic [7:0]    sig0_r, sig1_r, sig2_r, sig0_s, sig1_s, sig2_s;
    logic [12:0]   byte_cnt_r, byte_cnt_s;
    logic [SW-1:0] skip_cnt_r, skip_cnt_s;
    logic [TW-1:0] to_cnt_r, to_cnt_s;

    logic          dec_reset_r, dec_enable_r, do_descramble_r, sig_valid_r, sig_error_r;
    logic          timeout_r, data_strobe_r, pkt_done_r, busy_r;
    logic [7:0]    rate_r, data_byte_r;
    logic [19:0]   nbits_r;
    logic [3:0]    pkt_rate_r;
    logic [11:0]   pkt_len_r;

    logic          dec_reset_s, dec_enable_s, do_descramble_s, sig_valid_s, sig_error_s;
    logic          timeout_s, data_strobe_s, pkt_done_s, busy_s;
    logic [7:0]    rate_s, data_byte_s;
    logic [19:0]   nbits_s;
    logic [3:0]    pkt_rate_s;
    logic [11:0]   pkt_len_s;

    logic [23:0]   sig_word_s;
    logic [11:0]   sig_len_s;
    logic          accept_s, strobe_s, waiting_s, to_hit_s, skipping_s, last_byte_s;

    assign sig_word_s  = {sig2_r, sig1_r, sig0_r};
    assign sig_len_s   = {sig2_r[0], sig1_r, sig0_r[7:5]};
    assign accept_s    = sig_ok(sig_word_s);
    assign strobe_s    = enable & byte_in_strobe;
    assign waiting_s   = (state_r == ST_SIG_WAIT) | (state_r == ST_DATA);
    assign to_hit_s    = enable & waiting_s & ~byte_in_strobe & ((to_cnt_r + TO_ONE) == TO_LIMIT);
    assign skipping_s  = (skip_cnt_r < SKIP_LIMIT);
    assign last_byte_s = ((byte_cnt_r + 13'd1) == {1'b0, pkt_len_r});

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; start overrides any byte strobe or timeout.
    always_comb begin
        next_state_s = state_r;
        if (!enable) begin
            next_state_s = state_r;
        end else if (start) begin
            next_state_s = ST_SIG_CFG;
        end else begin
            case (state_r)
                ST_IDLE:      next_state_s = ST_IDLE;
                ST_SIG_CFG:   next_state_s = ST_SIG_WAIT;
                ST_SIG_WAIT: begin
                    if (byte_in_strobe && (byte_cnt_r[1:0] == 2'd2)) begin
                        next_state_s = ST_SIG_CHECK;
                    end else if (to_hit_s) begin
                        next_state_s = ST_IDLE;
                    end else begin
                        next_state_s = ST_SIG_WAIT;
                    end
                end
                ST_SIG_CHECK: next_state_s = accept_s ? ST_DATA_CFG : ST_IDLE;
                ST_DATA_CFG:  next_state_s = ST_DATA;
                ST_DATA: begin
                    if (byte_in_strobe && !skipping_s && last_byte_s) begin
                        next_state_s = ST_IDLE;
                    end else if (to_hit_s) begin
                        next_state_s = ST_IDLE;
                    end else begin
                        next_state_s = ST_DATA;
                    end
                end
                default:      next_state_s = ST_IDLE;
            endcase
        end
    end

    // Next values for counters, SIG capture and every registered output.
    always_comb begin
        sig0_s          = sig0_r;
        sig1_s          = sig1_r;
        sig2_s          = sig2_r;
        byte_cnt_s      = byte_cnt_r;
        skip_cnt_s      = skip_cnt_r;
        to_cnt_s        = to_cnt_r;
        rate_s          = rate_r;
        do_descramble_s = do_descramble_r;
        nbits_s         = nbits_r;
        pkt_rate_s      = pkt_rate_r;
        pkt_len_s       = pkt_len_r;
        data_byte_s     = data_byte_r;
        dec_reset_s     = 1'b0;
        sig_valid_s     = 1'b0;
        sig_error_s     = 1'b0;
        timeout_s       = 1'b0;
        data_strobe_s   = 1'b0;
        pkt_done_s      = 1'b0;
        busy_s          = (next_state_s != ST_IDLE);
        dec_enable_s    = (next_state_s == ST_SIG_WAIT) | (next_state_s == ST_DATA);
        if (!enable) begin
            dec_reset_s = 1'b0;
        end else if (next_state_s == ST_SIG_CFG) begin
            dec_reset_s     = 1'b1;
            rate_s          = 8'h0B;
            do_descramble_s = 1'b0;
            nbits_s         = 20'd24;
            byte_cnt_s      = 13'd0;
            skip_cnt_s      = '0;
            to_cnt_s        = '0;
        end else if (state_r == ST_SIG_CHECK) begin
            if (accept_s) begin
                dec_reset_s     = 1'b1;
                sig_valid_s     = 1'b1;
                rate_s          = {4'h0, sig0_r[3:0]};
                do_descramble_s = 1'b1;
                nbits_s         = {5'd0, sig_len_s, 3'd0} + 20'd22;
                pkt_rate_s      = sig0_r[3:0];
                pkt_len_s       = sig_len_s;
                byte_cnt_s      = 13'd0;
                skip_cnt_s      = '0;
                to_cnt_s        = '0;
            end else begin
                sig_error_s = 1'b1;
            end
        end else if (state_r == ST_SIG_WAIT) begin
            if (strobe_s) begin
                case (byte_cnt_r[1:0])
                    2'd0:    sig0_s = byte_in;
                    2'd1:    sig1_s = byte_in;
                    default: sig2_s = byte_in;
                endcase
                byte_cnt_s = byte_cnt_r + 13'd1;
                to_cnt_s   = '0;
            end else if (to_hit_s) begin
                timeout_s = 1'b1;
                to_cnt_s  = '0;
            end else begin
                to_cnt_s = to_cnt_r + TO_ONE;
            end
        end else if (state_r == ST_DATA) begin
            if (strobe_s) begin
                to_cnt_s = '0;
                if (skipping_s) begin
                    skip_cnt_s = skip_cnt_r + SKIP_ONE;
                end else begin
                    data_strobe_s = 1'b1;
                    data_byte_s   = byte_in;
                    byte_cnt_s    = byte_cnt_r + 13'd1;
                    pkt_done_s    = last_byte_s;
                end
            end else if (to_hit_s) begin
                timeout_s = 1'b1;
                to_cnt_s  = '0;
            end else begin
                to_cnt_s = to_cnt_r + TO_ONE;
            end
        end else begin
            dec_reset_s = 1'b0;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            sig0_r          <= 8'd0;
            sig1_r          <= 8'd0;
            sig2_r          <= 8'd0;
            byte_cnt_r      <= 13'd0;
            skip_cnt_r      <= '0;
            to_cnt_r        <= '0;
            dec_reset_r     <= 1'b0;
            dec_enable_r    <= 1'b0;
            rate_r          <= 8'd0;
            do_descramble_r <= 1'b0;
            nbits_r         <= 20'd0;
            sig_valid_r     <= 1'b0;
            sig_error_r     <= 1'b0;
            timeout_r       <= 1'b0;
            pkt_rate_r      <= 4'd0;
            pkt_len_r       <= 12'd0;
            data_byte_r     <= 8'd0;
            data_strobe_r   <= 1'b0;
            pkt_done_r      <= 1'b0;
            busy_r          <= 1'b0;
        end else begin
            sig0_r          <= sig0_s;
            sig1_r          <= sig1_s;
            sig2_r          <= sig2_s;
            byte_cnt_r      <= byte_cnt_s;
            skip_cnt_r      <= skip_cnt_s;
            to_cnt_r        <= to_cnt_s;
            dec_reset_r     <= dec_reset_s;
            dec_enable_r    <= dec_enable_s;
            rate_r          <= rate_s;
            do_descramble_r <= do_descramble_s;
            nbits_r         <= nbits_s;
            sig_valid_r     <= sig_valid_s;
            sig_error_r     <= sig_error_s;
            timeout_r       <= timeout_s;
            pkt_rate_r      <= pkt_rate_s;
            pkt_len_r       <= pkt_len_s;
            data_byte_r     <= data_byte_s;
            data_strobe_r   <= data_strobe_s;
            pkt_done_r      <= pkt_done_s;
            busy_r          <= busy_s;
        end
    end

    assign dec_reset          = dec_reset_r;
    assign dec_enable         = dec_enable_r;
    assign rate               = rate_r;
    assign do_descramble      = do_descramble_r;
    assign num_bits_to_decode = nbits_r;
    assign sig_valid          = sig_valid_r;
    assign sig_error          = sig_error_r;
    assign timeout            = timeout_r;
    assign pkt_rate           = pkt_rate_r;
    assign pkt_len            = pkt_len_r;
    assign data_byte          = data_byte_r;
    assign data_strobe        = data_strobe_r;
    assign pkt_done           = pkt_done_r;
    assign busy               = busy_r;

endmodule

// File: tb/tb_ofdm_decode_sequencer.sv
// Directed self-checking bench for ofdm_decode_sequencer. Two instances share
// the stimulus: u_dut (no skipped bytes) and u_skip (two skipped bytes), both
// with a short 16-cycle byte timeout.
module tb_ofdm_decode_sequencer;

    logic        clock = 1'b0;
    logic        reset, enable, start, byte_in_strobe;
    logic [7:0]  byte_in;

    logic        dec_reset, dec_enable, do_descramble, sig_valid, sig_error;
    logic        timeout, data_strobe, pkt_done, busy;
    logic [7:0]  rate, data_byte;
    logic [19:0] num_bits_to_decode;
    logic [3:0]  pkt_rate;
    logic [11:0] pkt_len;

    logic        sk_dec_reset, sk_dec_enable, sk_do_descramble, sk_sig_valid, sk_sig_error;
    logic        sk_timeout, sk_data_strobe, sk_pkt_done, sk_busy;
    logic [7:0]  sk_rate, sk_data_byte;
    logic [19:0] sk_num_bits;
    logic [3:0]  sk_pkt_rate;
    logic [11:0] sk_pkt_len;

    int checks = 0;
    int errors = 0;

    ofdm_decode_sequencer #(.MAX_LEN(4095), .SKIP_BYTES(0), .TIMEOUT_CYCLES(16)) u_dut (
        .clock(clock), .reset(reset), .enable(enable), .start(start),
        .byte_in(byte_in), .byte_in_strobe(byte_in_strobe),
        .dec_reset(dec_reset), .dec_enable(dec_enable), .rate(rate),
        .do_descramble(do_descramble), .num_bits_to_decode(num_bits_to_decode),
        .sig_valid(sig_valid), .sig_error(sig_error), .timeout(timeout),
        .pkt_rate(pkt_rate), .pkt_len(pkt_len), .data_byte(data_byte),
        .data_strobe(data_strobe), .pkt_done(pkt_done), .busy(busy)
    );

    ofdm_decode_sequencer #(.MAX_LEN(4095), .SKIP_BYTES(2), .TIMEOUT_CYCLES(16)) u_skip (
        .clock(clock), .reset(reset), .enable(enable), .start(start),
        .byte_in(byte_in), .byte_in_strobe(byte_in_strobe),
        .dec_reset(sk_dec_reset), .dec_enable(sk_dec_enable), .rate(sk_rate),
        .do_descramble(sk_do_descramble), .num_bits_to_decode(sk_num_bits),
        .sig_valid(sk_sig_valid), .sig_error(sk_sig_error), .timeout(sk_timeout),
        .pkt_rate(sk_pkt_rate), .pkt_len(sk_pkt_len), .data_byte(sk_data_byte),
        .data_strobe(sk_data_strobe), .pkt_done(sk_pkt_done), .busy(sk_busy)
    );

    // 100 MHz clock.
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulse start and check the SIG configuration cycle and decoder enable.
    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        byte_in_strobe = 1'b0;
        chk("start_dec_reset", 32'(dec_reset), 32'd1);
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_dec_enable_low", 32'(dec_enable), 32'd0);
        chk("start_rate", 32'(rate), 32'h0B);
        chk("start_descramble", 32'(do_descramble), 32'd0);
        chk("start_nbits", 32'(num_bits_to_decode), 32'd24);
        chk("start_no_data", 32'({data_strobe, pkt_done}), 32'd0);
        tick();
        chk("sigwait_dec_enable", 32'(dec_enable), 32'd1);
        chk("sigwait_dec_reset", 32'(dec_reset), 32'd0);
    endtask

    // Three SIG strobes; returns two cycles after the third (the verdict cycle).
    task automatic send_sig(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        byte_in = b0; byte_in_strobe = 1'b1; tick();
        byte_in = b1; tick();
        byte_in = b2; tick();
        byte_in_strobe = 1'b0;
        chk("sig_check_quiet", 32'({sig_valid, sig_error}), 32'd0);
        tick();
    endtask

    task automatic expect_accept(input logic [3:0] r, input logic [11:0] len);
        logic [19:0] nb;
        nb = 20'd22 + (20'(len) << 3);
        chk("acc_sig_valid", 32'(sig_valid), 32'd1);
        chk("acc_sig_error", 32'(sig_error), 32'd0);
        chk("acc_dec_reset", 32'(dec_reset), 32'd1);
        chk("acc_rate", 32'(rate), 32'({4'h0, r}));
        chk("acc_descramble", 32'(do_descramble), 32'd1);
        chk("acc_nbits", 32'(num_bits_to_decode), 32'(nb));
        chk("acc_pkt_rate", 32'(pkt_rate), 32'(r));
        chk("acc_pkt_len", 32'(pkt_len), 32'(len));
        chk("acc_busy", 32'(busy), 32'd1);
        tick();
        chk("data_pulses_clear", 32'({sig_valid, dec_reset}), 32'd0);
    endtask

    task automatic expect_reject();
        chk("rej_sig_error", 32'(sig_error), 32'd1);
        chk("rej_sig_valid", 32'(sig_valid), 32'd0);
        chk("rej_dec_reset", 32'(dec_reset), 32'd0);
        chk("rej_busy", 32'(busy), 32'd0);
        chk("rej_dec_enable", 32'(dec_enable), 32'd0);
        tick();
        chk("rej_pulse_clear", 32'(sig_error), 32'd0);
    endtask

    // Stream n bytes base, base+1, ... and check each forwarded byte of u_dut.
    task automatic send_payload(input int n, input logic [7:0] base, input logic fin);
        logic [7:0] b;
        logic [9:0] e;
        for (int i = 0; i < n; i++) begin
            b = base + 8'(i);
            byte_in = b;
            byte_in_strobe = 1'b1;
            tick();
            e = {1'b1, (fin && (i == n - 1)), b};
            chk("payload", 32'({data_strobe, pkt_done, data_byte}), 32'(e));
        end
        byte_in_strobe = 1'b0;
        chk("payload_busy", 32'(busy), 32'(!fin));
    endtask

    logic [23:0] rej_tab [5];
    logic [23:0] v;
    logic [9:0]  e10;

    initial begin
        rej_tab[0] = 24'h8B0C02;  // parity flipped
        rej_tab[1] = 24'h800C00;  // rate 0
        rej_tab[2] = 24'h9B0C00;  // reserved bit set
        rej_tab[3] = 24'h8B0C04;  // tail nonzero
        rej_tab[4] = 24'h0B0002;  // len 0, even parity

        reset = 1'b1; enable = 1'b1; start = 1'b0; byte_in_strobe = 1'b0; byte_in = 8'd0;
        repeat (3) tick();
        chk("rst_flags", 32'({dec_reset, dec_enable, busy, sig_valid, sig_error, timeout, data_strobe, pkt_done}), 32'd0);
        chk("rst_rate", 32'(rate), 32'd0);
        chk("rst_descramble", 32'(do_descramble), 32'd0);
        chk("rst_nbits", 32'(num_bits_to_decode), 32'd0);
        chk("rst_pkt", 32'({pkt_rate, pkt_len}), 32'd0);
        chk("rst_data_byte", 32'(data_byte), 32'd0);
        reset = 1'b0;
        tick();

        // Good packet: rate 6M, len 100, payload 00..63.
        do_start();
        send_sig(8'h8B, 8'h0C, 8'h00);
        expect_accept(4'hB, 12'd100);
        send_payload(100, 8'h00, 1'b1);
        tick();
        chk("good_after", 32'({data_strobe, pkt_done}), 32'd0);

        // SIG rejections.
        for (int k = 0; k < 5; k++) begin
            v = rej_tab[k];
            do_start();
            send_sig(v[23:16], v[15:8], v[7:0]);
            expect_reject();
        end

        // Timeout after two SIG bytes.
        do_start();
        byte_in = 8'h8B; byte_in_strobe = 1'b1; tick();
        byte_in = 8'h0C; tick();
        byte_in_strobe = 1'b0;
        repeat (15) tick();
        chk("to_early", 32'({timeout, busy}), 32'b01);
        tick();
        chk("to_fire", 32'({timeout, busy}), 32'b10);
        tick();
        chk("to_pulse_clear", 32'(timeout), 32'd0);
        do_start();
        send_sig(8'h2B, 8'h00, 8'h00);
        expect_accept(4'hB, 12'd1);
        send_payload(1, 8'h77, 1'b1);

        // Restart mid-DATA with a simultaneous strobe; then a 1-byte packet.
        do_start();
        send_sig(8'h8B, 8'h0C, 8'h00);
        expect_accept(4'hB, 12'd100);
        send_payload(10, 8'h40, 1'b0);
        byte_in = 8'hAA;
        byte_in_strobe = 1'b1;
        do_start();
        send_sig(8'h2B, 8'h00, 8'h00);
        expect_accept(4'hB, 12'd1);
        send_payload(1, 8'h5A, 1'b1);

        // Enable gating mid-DATA: len 10.
        do_start();
        send_sig(8'h4B, 8'h01, 8'h02);
        expect_accept(4'hB, 12'd10);
        send_payload(4, 8'h10, 1'b0);
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            byte_in = 8'hE0 + 8'(i);
            byte_in_strobe = 1'b1;
            tick();
            chk("dis_no_strobe", 32'({data_strobe, pkt_done}), 32'd0);
            chk("dis_hold", 32'({busy, data_byte}), 32'h113);
        end
        enable = 1'b1;
        send_payload(6, 8'h14, 1'b1);

        // SKIP_BYTES=2 on u_skip with len 3; u_dut forwards the first three.
        do_start();
        byte_in = 8'h6B; byte_in_strobe = 1'b1; tick();
        byte_in = 8'h00; tick();
        byte_in = 8'h02; tick();
        byte_in_strobe = 1'b0;
        tick();
        chk("skip_sig", 32'({sk_sig_valid, sk_pkt_len}), 32'h1003);
        expect_accept(4'hB, 12'd3);
        for (int i = 0; i < 5; i++) begin
            byte_in = 8'hA0 + 8'(i);
            byte_in_strobe = 1'b1;
            tick();
            if (i < 2) begin
                chk("skip_dropped", 32'({sk_data_strobe, sk_pkt_done}), 32'd0);
            end else begin
                e10 = {1'b1, (i == 4), 8'hA0 + 8'(i)};
                chk("skip_fwd", 32'({sk_data_strobe, sk_pkt_done, sk_data_byte}), 32'(e10));
            end
            if (i < 3) begin
                e10 = {1'b1, (i == 2), 8'hA0 + 8'(i)};
                chk("noskip_fwd", 32'({data_strobe, pkt_done, data_byte}), 32'(e10));
            end else begin
                chk("idle_ignore", 32'({data_strobe, pkt_done}), 32'd0);
            end
        end
        byte_in_strobe = 1'b0;
        chk("skip_busy", 32'({sk_busy, busy}), 32'd0);

        // Reset in the middle of SIG_WAIT.
        do_start();
        byte_in = 8'h8B; byte_in_strobe = 1'b1; tick();
        byte_in_strobe = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_busy", 32'({busy, dec_enable}), 32'd0);
        chk("midrst_cfg", 32'({rate, pkt_len}), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
